// File: rtl/truth_table_sweeper.sv
// Drives every input vector of a combinational function in turn, captures its
// output into a truth table and counts disagreements with a golden table.
module truth_table_sweeper #(
  parameter int NIN = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [2:0]           n_inputs,
  input  logic [1:0]           settle,
  input  logic [2**NIN-1:0]    expected,
  output logic [NIN-1:0]       vec_out,
  input  logic                 f_in,
  output logic                 busy,
  output logic                 done,
  output logic [2**NIN-1:0]    table_out,
  output logic [NIN:0]         mismatch_cnt,
  output logic                 pass
);
  localparam int TW = 2**NIN;

  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  state_t state;

  logic [NIN-1:0] last_vec;
  logic [1:0]     s_lat, wait_cnt;
  logic [NIN:0]   span, mc_next;
  logic           miss;
  int             n_eff;

  // Index of the final vector for the requested width; 0 or oversize means full width.
  always_comb begin
    n_eff = int'(n_inputs);
    if (n_eff == 0 || n_eff > NIN) n_eff = NIN;
    span = ((NIN+1)'(1) << n_eff) - (NIN+1)'(1);
  end

  assign miss    = f_in != expected[vec_out];
  assign mc_next = (miss && mismatch_cnt != (NIN+1)'(TW)) ? mismatch_cnt + (NIN+1)'(1)
                                                           : mismatch_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      vec_out      <= '0;
      table_out    <= '0;
      mismatch_cnt <= '0;
      last_vec     <= '0;
      s_lat        <= '0;
      wait_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state        <= DRIVE;
            busy         <= 1'b1;
            pass         <= 1'b0;
            vec_out      <= '0;
            table_out    <= '0;
            mismatch_cnt <= '0;
            last_vec     <= span[NIN-1:0];
            s_lat        <= settle;
            wait_cnt     <= '0;
          end
        end
        DRIVE: begin
          if (abort) begin
            // Cancel wins over a sample due this cycle; partial results stay visible.
            state    <= IDLE;
            busy     <= 1'b0;
            pass     <= 1'b0;
            vec_out  <= '0;
            wait_cnt <= '0;
          end else if (wait_cnt == s_lat) begin
            table_out[vec_out] <= f_in;
            mismatch_cnt       <= mc_next;
            wait_cnt           <= '0;
            if (vec_out == last_vec) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              pass    <= (mc_next == '0);
              vec_out <= '0;
            end else begin
              vec_out <= vec_out + 1'b1;
            end
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
